// File: rtl/memoria_pkg.sv
// rtl/memoria_pkg.sv - shared widths, state encoding and helpers for memoria_principal
package memoria_pkg;

    localparam int ADDR_W          = 5;
    localparam int DATA_W          = 3;
    localparam int DEPTH           = 32;
    localparam int CNT_W           = 4;
    localparam int STAT_W          = 8;
    localparam int LATENCY_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Completion counters stick at their maximum instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == {STAT_W{1'b1}}) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/memoria_principal_contador_latencia.sv
// rtl/memoria_principal_contador_latencia.sv - loadable down-counter with zero flag
module contador_latencia
    import memoria_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memoria_principal.sv
// rtl/memoria_principal.sv - fixed-latency main-memory responder for cache fills and write-backs
module memoria_principal
    import memoria_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(LATENCY - 1);

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic                finish;
    logic                cnt_zero;
    logic [CNT_W-1:0]    cnt_value;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign accept = req && (state == IDLE);
    assign finish = (state == ACCESS) && cnt_zero;

    contador_latencia #(
        .WIDTH(CNT_W)
    ) u_contador (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .load_value(LOAD_VALUE),
        .dec       (state == ACCESS),
        .count     (cnt_value),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        ack        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                ack        = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = ~ready;

    // Transaction fields are frozen at acceptance; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // The array is committed on the ACCESS->DONE edge so a following read sees it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
            rdata <= '0;
        end else if (finish) begin
            if (we_q) begin
                mem[addr_q] <= wdata_q;
            end else begin
                rdata <= mem[addr_q];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == DONE) begin
            if (we_q) begin
                wr_count <= sat_inc(wr_count);
            end else begin
                rd_count <= sat_inc(rd_count);
            end
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^cnt_value;

endmodule
